// File: rtl/ws2812_pkg.sv
// ws2812_pkg: definitions shared by the WS2812 receiver and transmitter.
//   ws2812_state_e   receiver protocol state (SYNC / RX / PASS)
//   ns_to_cycles()   converts a duration in ns to whole clk cycles, rounding up
//   *Ns constants    protocol timing in ns used to derive cycle parameters
package ws2812_pkg;

    typedef enum logic [1:0] {
        StSync = 2'd0,
        StRx   = 2'd1,
        StPass = 2'd2
    } ws2812_state_e;

    localparam int unsigned BitsPerWord = 24;
    localparam int unsigned T1ThreshNs  = 600;    // high-time at or above this decodes as 1
    localparam int unsigned TResetNs    = 50000;  // low gap that marks end-of-frame
    localparam int unsigned THighMaxNs  = 5000;   // longest legal high-time

    function automatic int unsigned ns_to_cycles(input int unsigned clk_mhz,
                                                 input int unsigned ns);
        return (clk_mhz * ns + 999) / 1000;
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: serial and colour-word signals of the WS2812 receiver.
//   din        serial data into the receiver (asynchronous)
//   rgb        last complete colour word, MSB first as transmitted
//   rgb_valid  single-cycle strobe, rgb updated
//   dout       serial stream forwarded to the next pixel
//   frame_err  single-cycle strobe on protocol error
// master: drives din (stimulus side). slave: the receiver.
interface ws2812_rx_if;
    import ws2812_pkg::*;

    logic                   din;
    logic [BitsPerWord-1:0] rgb;
    logic                   rgb_valid;
    logic                   dout;
    logic                   frame_err;

    modport master (output din, input rgb, input rgb_valid, input dout, input frame_err);
    modport slave  (input din, output rgb, output rgb_valid, output dout, output frame_err);
endinterface

// File: rtl/ws2812_sync.sv
// ws2812_sync: 2-flop synchroniser for the asynchronous serial input plus edge detect.
//   clk, reset  clock and synchronous active-high reset
//   din_i       asynchronous serial input
//   ds_o        synchronised serial level
//   rise_o      ds_o is high this cycle and was low the cycle before
//   fall_o      ds_o is low this cycle and was high the cycle before
module ws2812_sync (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic ds_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, ds_q, ds_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b0;
            ds_q      <= 1'b0;
            ds_prev_q <= 1'b0;
        end else begin
            meta_q    <= din_i;
            ds_q      <= meta_q;
            ds_prev_q <= ds_q;
        end
    end

    assign ds_o   = ds_q;
    assign rise_o = ds_q & ~ds_prev_q;
    assign fall_o = ~ds_q & ds_prev_q;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 pixel receiver. Waits for a reset gap, decodes the first 24-bit word
// from pulse high-times, then forwards the rest of the frame on dout until the next gap.
//   clk, reset  clock and synchronous active-high reset
//   bus         ws2812_rx_if.slave: din in; rgb, rgb_valid, dout, frame_err out
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_MHZ     = 12,
    parameter int unsigned T_THRESH    = ns_to_cycles(CLK_MHZ, T1ThreshNs),
    parameter int unsigned T_RESET_DET = ns_to_cycles(CLK_MHZ, TResetNs),
    parameter int unsigned T_HIGH_MAX  = ns_to_cycles(CLK_MHZ, THighMaxNs)
) (
    input  logic clk,
    input  logic reset,
    ws2812_rx_if.slave bus
);
    localparam int unsigned HiW = $clog2(T_HIGH_MAX + 1) + 1;
    localparam int unsigned LoW = $clog2(T_RESET_DET) + 1;
    localparam logic [HiW-1:0] HiSat    = HiW'(T_HIGH_MAX + 1);
    localparam logic [HiW-1:0] HiMax    = HiW'(T_HIGH_MAX);
    localparam logic [HiW-1:0] HiThresh = HiW'(T_THRESH);
    localparam logic [LoW-1:0] LoSat    = LoW'(T_RESET_DET);
    localparam logic [LoW-1:0] LoLast   = LoW'(T_RESET_DET - 1);
    localparam logic [4:0]     IdxTop   = 5'd23;

    logic ds, rise, fall;

    ws2812_state_e          state_q, state_d;
    logic [HiW-1:0]         hi_cnt_q, hi_cnt_d;
    logic [LoW-1:0]         lo_cnt_q, lo_cnt_d;
    logic [4:0]             idx_q, idx_d;
    logic [BitsPerWord-1:0] shift_q, shift_d;
    logic [BitsPerWord-1:0] rgb_q, rgb_d;
    logic                   load_q, load_d;
    logic                   rgb_valid_q, rgb_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   dout_q, dout_d;

    logic gap_evt, hi_over, bit_val;

    ws2812_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .din_i  (bus.din),
        .ds_o   (ds),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Fires once per low run, on the cycle the low count reaches T_RESET_DET.
    assign gap_evt = ~ds && (lo_cnt_q == LoLast);
    // Fires once, on the first high cycle beyond T_HIGH_MAX.
    assign hi_over = ds && !rise && (hi_cnt_q == HiMax);
    assign bit_val = (hi_cnt_q >= HiThresh);

    // Saturating counters; the rise cycle itself is the first counted high cycle.
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (rise) begin
            hi_cnt_d = HiW'(1);
        end else if (ds && hi_cnt_q != HiSat) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
        end
        lo_cnt_d = lo_cnt_q;
        if (ds) begin
            lo_cnt_d = '0;
        end else if (lo_cnt_q != LoSat) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSync;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            idx_q       <= IdxTop;
            shift_q     <= '0;
            rgb_q       <= '0;
            load_q      <= 1'b0;
            rgb_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rgb_q       <= rgb_d;
            load_q      <= load_d;
            rgb_valid_q <= rgb_valid_d;
            frame_err_q <= frame_err_d;
            dout_q      <= dout_d;
        end
    end

    // Next state: the reset gap outranks every other event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync: if (gap_evt) state_d = StRx;
            StRx: begin
                if (gap_evt)                      state_d = StRx;
                else if (hi_over)                 state_d = StSync;
                else if (fall && idx_q == 5'd0)   state_d = StPass;
            end
            StPass: begin
                if (gap_evt)      state_d = StRx;
                else if (hi_over) state_d = StSync;
            end
            default: state_d = StSync;
        endcase
    end

    // Outputs and datapath.
    always_comb begin
        idx_d       = idx_q;
        shift_d     = shift_q;
        rgb_d       = rgb_q;
        load_d      = 1'b0;
        rgb_valid_d = 1'b0;
        frame_err_d = 1'b0;
        dout_d      = 1'b0;
        // rgb takes the word the clock after its last bit was shifted in.
        if (load_q) begin
            rgb_d       = shift_q;
            rgb_valid_d = 1'b1;
        end
        unique case (state_q)
            StSync: if (gap_evt) idx_d = IdxTop;
            StRx: begin
                if (gap_evt) begin
                    idx_d       = IdxTop;
                    frame_err_d = (idx_q != IdxTop);
                end else if (hi_over) begin
                    idx_d       = IdxTop;
                    frame_err_d = 1'b1;
                end else if (fall) begin
                    shift_d = {shift_q[BitsPerWord-2:0], bit_val};
                    if (idx_q == 5'd0) begin
                        idx_d  = IdxTop;
                        load_d = 1'b1;
                    end else begin
                        idx_d = idx_q - 5'd1;
                    end
                end
            end
            StPass: begin
                if (gap_evt) idx_d = IdxTop;
                else if (!hi_over) dout_d = ds;
            end
            default: idx_d = IdxTop;
        endcase
    end

    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.dout      = dout_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized and directed stimulus for ws2812_rx. A pulse-level reference model
// predicts rgb words, frame errors and forwarded dout pulse widths; a monitor checks them.
module tb_ws2812_rx;
    localparam int THRESH = 8;
    localparam int GAP    = 600;
    localparam int HMAX   = 60;

    typedef struct packed {
        logic        is_err;
        logic [23:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    ev_t exp_q[$];
    int  dexp_q[$];

    // Reference model state
    bit          m_armed, m_fwd, m_gap_done;
    int          m_nbits, m_low_run;
    logic [23:0] m_word, m_rgb;

    ws2812_rx_if bus ();

    ws2812_rx #(.CLK_MHZ(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic is_err, input logic [23:0] val);
        ev_t e;
        e.is_err = is_err;
        e.val    = val;
        exp_q.push_back(e);
    endtask

    task automatic send_low(input int n);
        if (!m_gap_done && m_low_run + n >= GAP) begin
            m_gap_done = 1;
            if (m_armed && !m_fwd && m_nbits > 0) push_ev(1'b1, 24'h0);
            m_armed = 1;
            m_fwd   = 0;
            m_nbits = 0;
        end
        m_low_run += n;
        drive(1'b0, n);
    endtask

    task automatic send_pulse(input int h, input int l);
        if (m_armed) begin
            if (m_fwd) begin
                dexp_q.push_back((h > HMAX) ? HMAX : h);
                if (h > HMAX) begin
                    m_armed = 0;
                    m_fwd   = 0;
                end
            end else if (h > HMAX) begin
                push_ev(1'b1, 24'h0);
                m_armed = 0;
                m_nbits = 0;
            end else begin
                m_word = {m_word[22:0], (h >= THRESH)};
                m_nbits++;
                if (m_nbits == 24) begin
                    push_ev(1'b0, m_word);
                    m_rgb   = m_word;
                    m_fwd   = 1;
                    m_nbits = 0;
                end
            end
        end
        m_low_run  = 0;
        m_gap_done = 0;
        drive(1'b1, h);
        send_low(l);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(11, 4);
        else   send_pulse(4, 11);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) send_pulse($urandom_range(1, 20), $urandom_range(2, 11));
    endtask

    task automatic do_reset();
        drive(1'b0, 10);
        reset = 1'b1;
        drive(1'b0, 3);
        reset = 1'b0;
        m_armed = 0; m_fwd = 0; m_nbits = 0; m_rgb = '0;
        m_low_run = 0; m_gap_done = 0;
    endtask

    // Monitor: pops expected events and forwarded pulse widths as the DUT produces them.
    initial begin : monitor
        int  run;
        int  w;
        ev_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.rgb_valid || bus.frame_err) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: got rgb_valid=%0b frame_err=%0b rgb=%06h, expected none",
                             bus.rgb_valid, bus.frame_err, bus.rgb);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err !== bus.frame_err || e.is_err === bus.rgb_valid ||
                        (!e.is_err && bus.rgb !== e.val)) begin
                        n_fail++;
                        $display("FAIL event: got err=%0b valid=%0b rgb=%06h, expected err=%0b rgb=%06h",
                                 bus.frame_err, bus.rgb_valid, bus.rgb, e.is_err, e.val);
                    end
                end
            end
            if (bus.dout) begin
                run++;
            end else if (run > 0) begin
                n_tests++;
                if (dexp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dout_pulse: got width %0d, expected no pulse", run);
                end else begin
                    w = dexp_q.pop_front();
                    if (run < w - 1 || run > w + 1) begin
                        n_fail++;
                        $display("FAIL dout_width: got %0d, expected %0d +/-1", run, w);
                    end
                end
                run = 0;
            end
        end
    end

    initial begin : stimulus
        bus.din = 1'b0;
        m_word  = '0;
        do_reset();
        check("reset_rgb", 32'(bus.rgb), 32'h0);
        check("reset_rgb_valid", 32'(bus.rgb_valid), 32'h0);
        check("reset_dout", 32'(bus.dout), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);

        // Single word after the initial gap
        send_low(GAP);
        send_word(24'hFF0080);
        drive(1'b0, 8);
        check("rgb_ff0080", 32'(bus.rgb), 32'hFF0080);

        // Two words: first decoded, second forwarded
        send_low(GAP);
        send_word(24'h123456);
        send_word(24'hABCDEF);
        send_low(20);
        check("rgb_hold_123456", 32'(bus.rgb), 32'h123456);

        // Partial word cut by a gap
        send_low(GAP);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        send_low(GAP);
        send_word(24'h00FF00);
        send_low(20);
        check("rgb_00ff00", 32'(bus.rgb), 32'h00FF00);

        // Stuck high in RX, then no decode until a new gap
        send_low(GAP);
        send_bit(1'b1);
        send_pulse(70, 5);
        send_word(24'h0F0F0F);
        check("rgb_after_err", 32'(bus.rgb), 32'h00FF00);
        send_low(GAP);
        send_word(24'h0F0F0F);

        // Threshold and high-time-limit boundaries
        send_low(GAP);
        for (int i = 0; i < 23; i++) send_pulse(i[0] ? 8 : 7, 5);
        send_pulse(HMAX, 5);
        send_pulse(HMAX + 1, 5);
        send_low(30);
        check("rgb_thresh", 32'(bus.rgb), 32'(m_rgb));

        // Reset-gap length boundary: 599 low cycles continue the word, 600 end it
        send_low(GAP);
        send_pulse(11, 4);
        send_low(595);
        send_rand_bits(23);
        send_pulse(11, 4);
        send_low(596);
        send_word(24'hC3A55A);

        // Reset mid-word, then a word with and without a preceding gap
        send_low(GAP);
        send_rand_bits(12);
        do_reset();
        check("rgb_after_reset", 32'(bus.rgb), 32'h0);
        send_word(24'h5A5A5A);
        send_low(20);
        check("rgb_no_gap", 32'(bus.rgb), 32'h0);
        send_low(GAP);
        send_word(24'h5A5A5A);

        // Randomized phase
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0, 1:    send_low($urandom_range(GAP, GAP + 40));
                2, 3, 4: send_rand_bits(24);
                5:       send_rand_bits($urandom_range(1, 23));
                6:       send_pulse($urandom_range(HMAX + 1, HMAX + 15), 5);
                7:       send_rand_bits($urandom_range(1, 8));
                8:       do_reset();
                default: send_word($urandom);
            endcase
        end

        send_low(30);
        check("rgb_final", 32'(bus.rgb), 32'(m_rgb));
        check("events_left", 32'(exp_q.size()), 32'h0);
        check("dout_pulses_left", 32'(dexp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
